// File: rtl/cr_iu_randclk_pkg.sv
// Shared encodings and constants for the IU random-clock enable scheduler.
// No logic; latency n/a; backpressure n/a.
package cr_iu_randclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int GRP_MAD      = 0;
  localparam int GRP_OPER_GPR = 1;
  localparam int GRP_PCGEN    = 2;
  localparam int GRP_RETIRE   = 3;
  localparam int GRP_WB_BUF   = 4;
  localparam int GRP_WB_CTRL  = 5;
  localparam int GRP_WB_IDX   = 6;

  localparam int NUM_GPR = 21;
  // Flat enable vector: [0] mad, [21:1] oper_gpr, [26:22] pcgen..wb_idx.
  localparam int NUM_EN  = NUM_GPR + 6;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_RST  = 16'hACE1;

  function automatic logic [NUM_EN-1:0] en_onehot(input logic [2:0] grp, input logic [4:0] idx);
    int pos;
    if (grp == 3'(GRP_OPER_GPR))
      pos = 1 + int'(idx);
    else if (grp == 3'(GRP_MAD))
      pos = 0;
    else
      pos = NUM_GPR - 1 + int'(grp);
    en_onehot = NUM_EN'(1) << pos;
  endfunction

endpackage

// File: rtl/cr_iu_randclk_lfsr.sv
// 16-bit Galois LFSR with step, load and zero-seed substitution.
// Latency: new value one cycle after step/load; no backpressure.
module cr_iu_randclk_lfsr #(
  parameter logic [15:0] SEED_RST = cr_iu_randclk_pkg::SEED_RST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);
  import cr_iu_randclk_pkg::*;

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= SEED_RST;
    else if (load)
      lfsr <= (seed == 16'h0000) ? SEED_RST : seed;  // all-zero would lock up
    else if (step)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/cr_iu_randclk_ctrl.sv
// LFSR-scheduled IU random-clock module enables with halt handshake; CR_IU_RANDCLK_FORCE_EN adds a force-all input.
// Latency: enable rises one cycle after a fire decision; all outputs registered; no backpressure.
module cr_iu_randclk_ctrl #(
  parameter int          DWELL    = 4,
  parameter int          GAP      = 2,
  parameter logic [15:0] SEED_RST = cr_iu_randclk_pkg::SEED_RST
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
`ifdef CR_IU_RANDCLK_FORCE_EN
  input  logic        had_randclk_force,
`endif
  input  logic        seu_randclk_en,
  input  logic [3:0]  seu_randclk_rate,
  input  logic [6:0]  seu_randclk_grp_mask,
  input  logic        seu_randclk_seed_vld,
  input  logic [15:0] seu_randclk_seed,
  input  logic        had_randclk_halt_req,
  output logic        randclk_halt_ack,
  output logic        randclk_mad_mod_en_w2,
  output logic [20:0] randclk_oper_gpr_mod_en_w32,
  output logic        randclk_pcgen_mod_en_w32,
  output logic        randclk_retire_mod_en_w2,
  output logic        randclk_wb_buf_mod_en_w32,
  output logic        randclk_wb_ctrl_mod_en_w2,
  output logic        randclk_wb_idx_mod_en_w5
);
  import cr_iu_randclk_pkg::*;

  localparam logic [3:0] DWELL_C = 4'(DWELL);
  localparam logic [3:0] GAP_C   = 4'(GAP);

  state_t              state;
  logic [3:0]          dwell;
  logic [3:0]          gap;
  logic [15:0]         lfsr;
  logic [NUM_EN-1:0]   en_vec;
  logic [NUM_EN-1:0]   en_vec_nxt;
  logic [NUM_EN-1:0]   mod_en;
  logic [2:0]          grp;
  logic [4:0]          idx;
  logic [7:0]          mask8;
  logic                run_req;
  logic                fire;
  logic                unused_lfsr_hi;

  assign run_req = seu_randclk_en && !had_randclk_halt_req;
  assign grp     = lfsr[6:4];
  assign idx     = lfsr[11:7];
  // Group 7 maps onto the padded zero bit, so it can never fire.
  assign mask8   = {1'b0, seu_randclk_grp_mask};
  assign unused_lfsr_hi = ^lfsr[15:12];

  assign fire = (state == ST_RUN) && run_req && (dwell == 4'd0) && (gap == 4'd0) &&
                (lfsr[3:0] < seu_randclk_rate) && mask8[grp] &&
                ((grp != 3'(GRP_OPER_GPR)) || (idx < 5'(NUM_GPR)));

  assign en_vec_nxt = fire ? en_onehot(grp, idx) : ((dwell <= 4'd1) ? '0 : en_vec);

  cr_iu_randclk_lfsr #(.SEED_RST(SEED_RST)) u_lfsr (
    .clk  (forever_cpuclk),
    .rst  (cpurst),
    .step (state != ST_IDLE),
    .load ((state == ST_IDLE) && seu_randclk_seed_vld),
    .seed (seu_randclk_seed),
    .lfsr (lfsr)
  );

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state            <= ST_IDLE;
      dwell            <= '0;
      gap              <= '0;
      en_vec           <= '0;
      randclk_halt_ack <= 1'b1;
    end else begin
      en_vec <= en_vec_nxt;
      if (fire) begin
        dwell <= DWELL_C;
      end else if (dwell != 4'd0) begin
        dwell <= dwell - 4'd1;
        if (dwell == 4'd1)
          gap <= GAP_C;
      end else if (gap != 4'd0) begin
        gap <= gap - 4'd1;
      end

      case (state)
        ST_IDLE: begin
          if (!seu_randclk_seed_vld && run_req) begin
            state            <= ST_RUN;
            randclk_halt_ack <= 1'b0;
          end else begin
            randclk_halt_ack <= 1'b1;
          end
        end
        ST_RUN: begin
          randclk_halt_ack <= 1'b0;
          if (!run_req)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (run_req) begin
            state            <= ST_RUN;
            randclk_halt_ack <= 1'b0;
          end else if (dwell <= 4'd1) begin
            // Leave on the edge that ends the last dwell cycle; pending gap is dropped.
            state            <= ST_IDLE;
            dwell            <= '0;
            gap              <= '0;
            randclk_halt_ack <= 1'b1;
          end else begin
            randclk_halt_ack <= 1'b0;
          end
        end
        default: begin
          state            <= ST_IDLE;
          randclk_halt_ack <= 1'b1;
        end
      endcase
`ifdef CR_IU_RANDCLK_FORCE_EN
      if (had_randclk_force)
        randclk_halt_ack <= 1'b0;
`endif
    end
  end

`ifdef CR_IU_RANDCLK_FORCE_EN
  logic [NUM_EN-1:0] mod_en_q;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)
      mod_en_q <= '0;
    else
      mod_en_q <= had_randclk_force ? '1 : en_vec_nxt;
  end

  assign mod_en = mod_en_q;
`else
  assign mod_en = en_vec;
`endif

  assign randclk_mad_mod_en_w2       = mod_en[0];
  assign randclk_oper_gpr_mod_en_w32 = mod_en[NUM_GPR:1];
  assign randclk_pcgen_mod_en_w32    = mod_en[NUM_GPR+1];
  assign randclk_retire_mod_en_w2    = mod_en[NUM_GPR+2];
  assign randclk_wb_buf_mod_en_w32   = mod_en[NUM_GPR+3];
  assign randclk_wb_ctrl_mod_en_w2   = mod_en[NUM_GPR+4];
  assign randclk_wb_idx_mod_en_w5    = mod_en[NUM_GPR+5];

endmodule

// File: tb/tb_cr_iu_randclk_ctrl.sv
// Randomised and directed bench for cr_iu_randclk_ctrl against a cycle-level behavioural model.
module tb_cr_iu_randclk_ctrl;

  localparam int          DW   = 4;
  localparam int          GP   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        cpurst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  rate = 4'd0;
  logic [6:0]  mask = 7'h00;
  logic        seed_vld = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        halt = 1'b0;

  logic        ack, mad, pcgen, retire, wb_buf, wb_ctrl, wb_idx;
  logic [20:0] gpr;

  always #5 clk = ~clk;

  cr_iu_randclk_ctrl #(.DWELL(DW), .GAP(GP), .SEED_RST(SEED)) dut (
    .forever_cpuclk              (clk),
    .cpurst                      (cpurst),
`ifdef CR_IU_RANDCLK_FORCE_EN
    .had_randclk_force           (1'b0),
`endif
    .seu_randclk_en              (en),
    .seu_randclk_rate            (rate),
    .seu_randclk_grp_mask        (mask),
    .seu_randclk_seed_vld        (seed_vld),
    .seu_randclk_seed            (seed),
    .had_randclk_halt_req        (halt),
    .randclk_halt_ack            (ack),
    .randclk_mad_mod_en_w2       (mad),
    .randclk_oper_gpr_mod_en_w32 (gpr),
    .randclk_pcgen_mod_en_w32    (pcgen),
    .randclk_retire_mod_en_w2    (retire),
    .randclk_wb_buf_mod_en_w32   (wb_buf),
    .randclk_wb_ctrl_mod_en_w2   (wb_ctrl),
    .randclk_wb_idx_mod_en_w5    (wb_idx)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int gpr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gal(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic any_en();
    return mad | (|gpr) | pcgen | retire | wb_buf | wb_ctrl | wb_idx;
  endfunction

  // Model: mode 0 idle, 1 run, 2 drain; left = high cycles still owed; cool = gap cycles owed.
  logic [15:0] m_lfsr;
  int m_mode, m_left, m_cool, m_grp, m_idx;
  bit m_ack;

  always @(posedge clk) begin : model
    bit go, fire;
    int g, ix;
    logic [15:0] nl;
    if (cpurst) begin
      m_lfsr = SEED; m_mode = 0; m_left = 0; m_cool = 0; m_grp = -1; m_idx = 0; m_ack = 1'b1;
    end else begin
      go = en && !halt;
      g  = int'(m_lfsr[6:4]);
      ix = int'(m_lfsr[11:7]);
      fire = (m_mode == 1) && go && (m_left == 0) && (m_cool == 0) && (m_lfsr[3:0] < rate) &&
             (g < 7) && mask[g] && ((g != 1) || (ix < 21));
      if (m_mode == 0 && seed_vld) nl = (seed == 16'h0000) ? SEED : seed;
      else if (m_mode != 0)        nl = gal(m_lfsr);
      else                         nl = m_lfsr;
      if (fire) begin
        m_grp = g; m_idx = ix; m_left = DW;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_grp = -1; m_cool = GP; end
      end else if (m_cool > 0) begin
        m_cool--;
      end
      case (m_mode)
        0: if (!seed_vld && go) m_mode = 1;
        1: if (!go) m_mode = 2;
        default: if (go) m_mode = 1;
                 else if (m_left == 0) begin m_mode = 0; m_cool = 0; end
      endcase
      m_ack  = (m_mode == 0);
      m_lfsr = nl;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("halt_ack", ack, m_ack);
      check("lfsr", dut.u_lfsr.lfsr, m_lfsr);
      check("mad", mad, m_grp == 0);
      check("oper_gpr", gpr, (m_grp == 1) ? (32'd1 << m_idx) : 32'd0);
      check("pcgen", pcgen, m_grp == 2);
      check("retire", retire, m_grp == 3);
      check("wb_buf", wb_buf, m_grp == 4);
      check("wb_ctrl", wb_ctrl, m_grp == 5);
      check("wb_idx", wb_idx, m_grp == 6);
      check("at_most_one", $countones({mad, gpr, pcgen, retire, wb_buf, wb_ctrl, wb_idx}) <= 1, 1);
    end
  end

  task automatic wait_rise(input string name);
    bit ok = 1'b0;
    logic prev = any_en();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (any_en() && !prev) begin ok = 1'b1; break; end
      prev = any_en();
    end
    check(name, ok, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    cpurst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_ack", ack, 1'b1);
    check("idle_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    check("idle_no_en", any_en(), 1'b0);

    seed_vld = 1'b1; seed = 16'h1234;
    @(negedge clk);
    check("seed_load", dut.u_lfsr.lfsr, 16'h1234);
    seed = 16'h0000;
    @(negedge clk);
    check("seed_zero_subst", dut.u_lfsr.lfsr, 16'hACE1);
    seed_vld = 1'b0; en = 1'b1; rate = 4'd15; mask = 7'h7F;
    @(negedge clk);
    check("run_ack_low", ack, 1'b0);
    check("first_not_yet", wb_idx, 1'b0);
    @(negedge clk);
    check("first_fire_wb_idx", wb_idx, 1'b1);
    check("first_step_lfsr", dut.u_lfsr.lfsr, 16'hE270);
    repeat (3) @(negedge clk);
    check("dwell4_high", wb_idx, 1'b1);
    @(negedge clk);
    check("dwell_end_low", wb_idx, 1'b0);
    repeat (300) @(negedge clk);

    rate = 4'd0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("rate0_silent", any_en(), 1'b0);
    end

    rate = 4'd15; mask = 7'h02;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (|gpr) gpr_seen++;
    end
    check("gpr_fired", gpr_seen > 0, 1'b1);

    mask = 7'h7F;
    wait_rise("halt_rise_timeout");
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    check("halt_dwell3", any_en(), 1'b1);
    @(negedge clk);
    check("halt_dwell4", any_en(), 1'b1);
    check("halt_ack_not_yet", ack, 1'b0);
    @(negedge clk);
    check("halt_en_off", any_en(), 1'b0);
    check("halt_ack_up", ack, 1'b1);
    halt = 1'b0;
    @(negedge clk);
    check("resume_ack_low", ack, 1'b0);

    wait_rise("rst_rise_timeout");
    repeat (2) @(negedge clk);
    cpurst = 1'b1;
    @(negedge clk);
    check("rst_en_off", any_en(), 1'b0);
    check("rst_ack", ack, 1'b1);
    check("rst_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    cpurst = 1'b0;

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 15) != 0);
      halt     = ($urandom_range(0, 31) == 0);
      seed_vld = ($urandom_range(0, 7) == 0);
      seed     = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ((i % 50) == 0) begin
        rate = 4'($urandom_range(0, 15));
        mask = 7'($urandom);
      end
    end
    en = 1'b0; halt = 1'b0; seed_vld = 1'b0;
    repeat (20) @(negedge clk);
    check("final_idle_ack", ack, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
